// File: rtl/bf_program_loader_if.sv
// Loader <-> host/prgmem signal bundle.
// The loader connects through the master modport; the byte source and the
// program memory observe it through the slave modport.
interface bf_program_loader_if #(
    parameter int PRGMEM_ADDR_WIDTH = 8
);
    logic                         i_start;
    logic                         i_rx_valid;
    logic [7:0]                   i_rx_data;
    logic                         o_rx_ready;
    logic                         o_prgmem_in;
    logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr;
    logic [2:0]                   o_prgmem_data;
    logic                         o_busy;
    logic                         o_done;
    logic [1:0]                   o_error;
    logic [PRGMEM_ADDR_WIDTH-1:0] o_length;

    modport master (
        input  i_start, i_rx_valid, i_rx_data,
        output o_rx_ready, o_prgmem_in, o_prgmem_addr, o_prgmem_data,
        output o_busy, o_done, o_error, o_length
    );

    modport slave (
        output i_start, i_rx_valid, i_rx_data,
        input  o_rx_ready, o_prgmem_in, o_prgmem_addr, o_prgmem_data,
        input  o_busy, o_done, o_error, o_length
    );
endinterface

// File: rtl/bf_program_loader.sv
// Brainfuck program loader: encodes an ASCII source stream into 3-bit opcodes,
// writes them to program memory from address 0, checks bracket balance and
// length, then appends HALT and zero-pads the rest of the memory.
module bf_program_loader #(
    parameter int         PRGMEM_ADDR_WIDTH = 8,
    parameter int         STACK_ADDR_WIDTH  = 4,
    parameter logic [7:0] TERM_CHAR         = 8'h21
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    bf_program_loader_if.master     bus
);
    localparam int AW = PRGMEM_ADDR_WIDTH;
    localparam int DW = STACK_ADDR_WIDTH + 1;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    // Deepest legal nesting; one more '[' is an overflow.
    localparam logic [DW-1:0] DEPTH_MAX = DW'(2 ** STACK_ADDR_WIDTH);

    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_LEFT = 3'b100;
    localparam logic [2:0] OP_RGHT = 3'b101;
    localparam logic [2:0] OP_OPEN = 3'b110;
    localparam logic [2:0] OP_CLOS = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [DW-1:0]   depth_reg, depth_next;
    logic [1:0]      error_reg, error_next;
    logic [AW-1:0]   length_reg, length_next;
    logic            wr_en_reg, wr_en_next;
    logic [2:0]      wr_data_reg, wr_data_next;

    logic            op_valid;
    logic [2:0]      op_code;
    logic            is_term;
    logic [AW-1:0]   wr_ptr_adv;

    // Byte classification: opcode characters, terminators, everything else is a comment.
    always_comb begin
        op_valid = 1'b0;
        op_code  = OP_HALT;
        is_term  = (bus.i_rx_data == TERM_CHAR) || (bus.i_rx_data == 8'h00);
        case (bus.i_rx_data)
            8'h2B: begin op_valid = 1'b1; op_code = OP_INC;  end // '+'
            8'h2D: begin op_valid = 1'b1; op_code = OP_DEC;  end // '-'
            8'h3E: begin op_valid = 1'b1; op_code = OP_RGHT; end // '>'
            8'h3C: begin op_valid = 1'b1; op_code = OP_LEFT; end // '<'
            8'h5B: begin op_valid = 1'b1; op_code = OP_OPEN; end // '['
            8'h5D: begin op_valid = 1'b1; op_code = OP_CLOS; end // ']'
            default: ;
        endcase
    end

    // The write pointer advances after each issued write, so the slot the next
    // opcode will land in is the pointer plus any write still on the bus.
    assign wr_ptr_adv = wr_ptr_reg + {{(AW-1){1'b0}}, wr_en_reg};

    // State register and all datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg   <= ST_IDLE;
            wr_ptr_reg  <= '0;
            depth_reg   <= '0;
            error_reg   <= 2'b00;
            length_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= OP_HALT;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            depth_reg   <= depth_next;
            error_reg   <= error_next;
            length_reg  <= length_next;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= wr_data_next;
        end
    end

    // Next-state logic: byte acceptance, bracket/length checks, HALT and padding.
    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_adv;
        depth_next   = depth_reg;
        error_next   = error_reg;
        length_next  = length_reg;
        wr_en_next   = 1'b0;
        wr_data_next = OP_HALT;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // A write still on the bus completes at the old address.
                if (bus.i_start) begin
                    state_next  = ST_LOAD;
                    wr_ptr_next = '0;
                    depth_next  = '0;
                    error_next  = 2'b00;
                    length_next = '0;
                end
            end

            ST_LOAD: begin
                if (bus.i_rx_valid) begin
                    if (is_term) begin
                        if (depth_reg != '0) begin
                            state_next = ST_ERR;
                            error_next = 2'b10;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_data_next = OP_HALT;
                            length_next  = wr_ptr_adv;
                            // HALT in the last slot leaves nothing to pad.
                            state_next   = (wr_ptr_adv == LAST_ADDR) ? ST_DONE : ST_PAD;
                        end
                    end else if (op_valid) begin
                        if (op_code == OP_CLOS && depth_reg == '0) begin
                            state_next = ST_ERR;
                            error_next = 2'b01;
                        end else if (op_code == OP_OPEN && depth_reg == DEPTH_MAX) begin
                            state_next = ST_ERR;
                            error_next = 2'b11;
                        end else if (wr_ptr_adv == LAST_ADDR) begin
                            // Last slot is kept for HALT.
                            state_next = ST_ERR;
                            error_next = 2'b11;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_data_next = op_code;
                            if (op_code == OP_OPEN) begin
                                depth_next = depth_reg + DW'(1);
                            end else if (op_code == OP_CLOS) begin
                                depth_next = depth_reg - DW'(1);
                            end
                        end
                    end
                end
            end

            ST_PAD: begin
                // A write is on the bus every PAD cycle; stop after the last address.
                if (wr_ptr_reg == LAST_ADDR) begin
                    state_next = ST_DONE;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_data_next = OP_HALT;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Output drive: write port straight from registers, status from state.
    assign bus.o_rx_ready    = (state_reg == ST_LOAD);
    assign bus.o_prgmem_in   = wr_en_reg;
    assign bus.o_prgmem_addr = wr_ptr_reg;
    assign bus.o_prgmem_data = wr_data_reg;
    assign bus.o_busy        = (state_reg == ST_LOAD) || (state_reg == ST_PAD);
    assign bus.o_done        = (state_reg == ST_DONE);
    assign bus.o_error       = error_reg;
    assign bus.o_length      = length_reg;
endmodule
